encoder_8b10b: RTL and testbench

Registered 8b/10b encoder per ANSI X3.230-1994: the transmit-side counterpart of the link's 8b/10b decoder. It sits between the lane data path and the serialiser in each PCIe lane. It maps a byte plus a control flag to a 10-bit symbol and tracks running disparity (RD) across symbols. It flags illegal K-code requests and applies the same optional bit-reversal and inversion controls as the receive side, so encoder and decoder can loop back symbol-for-symbol.

---
 rtl/encoder_8b10b.sv | 149 ++++++++++++++
 tb/tb_encoder_8b10b.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8b10b.sv
// Registered 8b/10b encoder with running-disparity tracking, K-code legality check
// and output bit-reversal / inversion matching the lane decoder.
module encoder_8b10b (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       control_i,
    input  logic       in_valid_i,
    input  logic       force_neg_disp_i,
    input  logic       bit_rev_i,
    input  logic       invert_data_out_i,
    output logic [9:0] data_o,
    output logic       out_valid_o,
    output logic       run_disp_o,
    output logic       code_err_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_legal, k_eff;
    logic       rd_s, rd6, rd_next;
    logic       unbal6, unbal4, alt7, kinv;
    logic [5:0] code6, six;
    logic [3:0] four;
    logic [9:0] sym, sym_rev, sym_out;

    logic [9:0] data_d, data_q;
    logic       out_valid_d, out_valid_q;
    logic       run_disp_d, run_disp_q;
    logic       code_err_d, code_err_q;

    assign x = data_i[4:0];
    assign y = data_i[7:5];

    assign k_legal = (x == 5'd28) ||
                     ((y == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
    assign k_eff   = control_i & k_legal;

    // 5b/6b codes at RD-, written abcdei with a in the MSB
    always_comb begin
        code6 = 6'b000000;
        case (x)
            5'd0:  code6 = 6'b100111;
            5'd1:  code6 = 6'b011101;
            5'd2:  code6 = 6'b101101;
            5'd3:  code6 = 6'b110001;
            5'd4:  code6 = 6'b110101;
            5'd5:  code6 = 6'b101001;
            5'd6:  code6 = 6'b011001;
            5'd7:  code6 = 6'b111000;
            5'd8:  code6 = 6'b111001;
            5'd9:  code6 = 6'b100101;
            5'd10: code6 = 6'b010101;
            5'd11: code6 = 6'b110100;
            5'd12: code6 = 6'b001101;
            5'd13: code6 = 6'b101100;
            5'd14: code6 = 6'b011100;
            5'd15: code6 = 6'b010111;
            5'd16: code6 = 6'b011011;
            5'd17: code6 = 6'b100011;
            5'd18: code6 = 6'b010011;
            5'd19: code6 = 6'b110010;
            5'd20: code6 = 6'b001011;
            5'd21: code6 = 6'b101010;
            5'd22: code6 = 6'b011010;
            5'd23: code6 = 6'b111010;
            5'd24: code6 = 6'b110011;
            5'd25: code6 = 6'b100110;
            5'd26: code6 = 6'b010110;
            5'd27: code6 = 6'b110110;
            5'd28: code6 = 6'b001110;
            5'd29: code6 = 6'b101110;
            5'd30: code6 = 6'b011110;
            5'd31: code6 = 6'b101011;
        endcase
    end

    always_comb begin
        rd_s   = force_neg_disp_i ? 1'b0 : run_disp_q;
        six    = (k_eff && x == 5'd28) ? 6'b001111 : code6;
        unbal6 = ($countones(six) != 3);
        // D.7 is balanced but still alternates with RD
        if (rd_s && (unbal6 || x == 5'd7)) six = ~six;
        rd6 = rd_s ^ unbal6;

        four = 4'b0111;
        case (y)
            3'd0: four = 4'b1011;
            3'd1: four = 4'b1001;
            3'd2: four = 4'b0101;
            3'd3: four = 4'b1100;
            3'd4: four = 4'b1101;
            3'd5: four = 4'b1010;
            3'd6: four = 4'b0110;
            3'd7: four = 4'b0111;
        endcase
        alt7 = (y == 3'd7) &&
               (k_eff ||
                (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        if (alt7) four = 4'b1110;
        // balanced K 4b codes are the D codes swapped between RD columns
        kinv = k_eff && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6);
        if (kinv) four = ~four;
        unbal4 = ($countones(four) != 2);
        if (rd6 && (unbal4 || y == 3'd3 || kinv)) four = ~four;
        rd_next = rd6 ^ unbal4;

        sym = '0;
        for (int i = 0; i < 6; i++) sym[i]     = six[5-i];
        for (int i = 0; i < 4; i++) sym[6+i]   = four[3-i];
        sym_rev = '0;
        for (int i = 0; i < 10; i++) sym_rev[i] = sym[9-i];
        sym_out = (bit_rev_i ? sym_rev : sym) ^ {10{invert_data_out_i}};
    end

    always_comb begin
        data_d      = data_q;
        run_disp_d  = run_disp_q;
        code_err_d  = code_err_q;
        out_valid_d = 1'b0;
        if (in_valid_i) begin
            data_d      = sym_out;
            run_disp_d  = rd_next;
            code_err_d  = control_i & ~k_legal;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q      <= 10'h000;
            out_valid_q <= 1'b0;
            run_disp_q  <= 1'b0;
            code_err_q  <= 1'b0;
        end else begin
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            run_disp_q  <= run_disp_d;
            code_err_q  <= code_err_d;
        end
    end

    assign data_o      = data_q;
    assign out_valid_o = out_valid_q;
    assign run_disp_o  = run_disp_q;
    assign code_err_o  = code_err_q;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Bench for encoder_8b10b: directed vector table, full D/K sweep, scoreboard
// queue popped by a monitor that also checks hold, reset and disparity rules.
module tb_encoder_8b10b;

    typedef struct packed {
        logic [9:0] out;
        logic       rd;
        logic       err;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] b;
        logic       k;
        logic       f;
        logic       rv;
        logic       iv;
        logic [9:0] out;
        logic       rd;
        logic       err;
    } vec_t;

    // RD- 6b codes (a = MSB) and 4b codes per RD after the 6b block (f = MSB)
    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] D4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b0111};
    localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b1110};
    localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [7:0] KC [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                       8'hF7, 8'hFB, 8'hFD, 8'hFE};

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       control_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       force_neg_disp_i = 1'b0;
    logic       bit_rev_i = 1'b0;
    logic       invert_data_out_i = 1'b0;
    logic [9:0] data_o;
    logic       out_valid_o, run_disp_o, code_err_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic mdl_rd = 1'b0;
    logic done = 1'b0;

    logic smp_rst = 1'b1, smp_vld = 1'b0, smp_frc = 1'b0, smp_rev = 1'b0, smp_inv = 1'b0;
    logic [9:0] held_out = '0;
    logic held_rd = 1'b0, held_err = 1'b0;
    exp_t mon_e;
    logic [9:0] raw, tmp;
    logic rd_start, disp_ok;
    int ones;

    always #5 clk_i = ~clk_i;

    encoder_8b10b dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .control_i(control_i),
        .in_valid_i(in_valid_i), .force_neg_disp_i(force_neg_disp_i), .bit_rev_i(bit_rev_i),
        .invert_data_out_i(invert_data_out_i), .data_o(data_o), .out_valid_o(out_valid_o),
        .run_disp_o(run_disp_o), .code_err_o(code_err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] b, input logic k, input logic rds,
                                   input logic rv, input logic iv);
        exp_t r;
        logic [4:0] x;
        logic [2:0] y;
        logic legal, rd6;
        logic [5:0] s6;
        logic [3:0] s4;
        logic [9:0] s, t;
        x = b[4:0];
        y = b[7:5];
        legal = k && ((x == 5'd28) ||
                      (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30)));
        r.err = k & ~legal;
        s6 = (legal && x == 5'd28) ? 6'b001111 : T6[x];
        if (rds && ($countones(s6) != 3 || x == 5'd7)) s6 = ~s6;
        rd6 = rds ^ ($countones(s6) != 3);
        if (legal) s4 = rd6 ? K4P[y] : K4N[y];
        else if (y == 3'd7 && ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                               ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
            s4 = rd6 ? 4'b0001 : 4'b1110;
        else s4 = rd6 ? D4P[y] : D4N[y];
        r.rd = rd6 ^ ($countones(s4) != 2);
        s = '0;
        for (int i = 0; i < 6; i++) s[i] = s6[5-i];
        for (int i = 0; i < 4; i++) s[6+i] = s4[3-i];
        t = s;
        if (rv) for (int i = 0; i < 10; i++) s[i] = t[9-i];
        if (iv) s = ~s;
        r.out = s;
        return r;
    endfunction

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] b, input logic k,
                                input logic f, input logic rv, input logic iv,
                                input logic [9:0] out, input logic rd, input logic err);
        vec_t t;
        t.rst = rst; t.v = v; t.b = b; t.k = k; t.f = f; t.rv = rv; t.iv = iv;
        t.out = out; t.rd = rd; t.err = err;
        return t;
    endfunction

    task automatic apply(input vec_t t, input logic use_tab);
        exp_t e;
        reset_i = t.rst; in_valid_i = t.v; data_i = t.b; control_i = t.k;
        force_neg_disp_i = t.f; bit_rev_i = t.rv; invert_data_out_i = t.iv;
        if (t.rst) mdl_rd = 1'b0;
        else if (t.v) begin
            if (use_tab) e = '{t.out, t.rd, t.err};
            else e = model(t.b, t.k, t.f ? 1'b0 : mdl_rd, t.rv, t.iv);
            sbq.push_back(e);
            mdl_rd = e.rd;
        end
        @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i) begin
        smp_rst <= reset_i;
        smp_vld <= in_valid_i;
        smp_frc <= force_neg_disp_i;
        smp_rev <= bit_rev_i;
        smp_inv <= invert_data_out_i;
    end

    always @(negedge clk_i) begin
        if (!done) begin
            if (smp_rst) begin
                chk("rst_out", data_o, 0);
                chk("rst_valid", out_valid_o, 0);
                chk("rst_rd", run_disp_o, 0);
                chk("rst_err", code_err_o, 0);
                held_out = '0; held_rd = 1'b0; held_err = 1'b0;
            end else if (smp_vld) begin
                chk("out_valid", out_valid_o, 1);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=%0h expected=none at %0t", data_o, $time);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sym", data_o, mon_e.out);
                    chk("rd", run_disp_o, mon_e.rd);
                    chk("code_err", code_err_o, mon_e.err);
                    raw = smp_inv ? ~data_o : data_o;
                    tmp = raw;
                    if (smp_rev) for (int i = 0; i < 10; i++) raw[i] = tmp[9-i];
                    rd_start = smp_frc ? 1'b0 : held_rd;
                    ones = $countones(raw);
                    disp_ok = rd_start ? ((ones == 5 && run_disp_o) || (ones == 4 && !run_disp_o))
                                       : ((ones == 5 && !run_disp_o) || (ones == 6 && run_disp_o));
                    chk("disparity", {31'd0, disp_ok}, 1);
                    held_out = mon_e.out; held_rd = mon_e.rd; held_err = mon_e.err;
                end
            end else begin
                chk("idle_valid", out_valid_o, 0);
                chk("hold_out", data_o, held_out);
                chk("hold_rd", run_disp_o, held_rd);
                chk("hold_err", code_err_o, held_err);
            end
        end
    end

    initial begin
        vec_t tab[$];
        logic [7:0] b;
        logic k;
        logic [1:0] ri;

        tab.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 10'h0B9, 0, 0));
        tab.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 10'h0B9, 0, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 0, 10'h17C, 1, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 0, 10'h283, 0, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 0, 10'h17C, 1, 0));
        tab.push_back(mk(0, 1, 8'hB5, 0, 0, 0, 0, 10'h155, 1, 0));
        tab.push_back(mk(0, 0, 8'h55, 1, 0, 1, 1, 10'h000, 0, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 0, 10'h283, 0, 0));
        tab.push_back(mk(0, 1, 8'hB5, 0, 0, 0, 0, 10'h155, 0, 0));
        tab.push_back(mk(0, 1, 8'hF1, 0, 0, 0, 0, 10'h1F1, 1, 0));
        tab.push_back(mk(0, 1, 8'h00, 1, 1, 0, 0, 10'h0B9, 0, 1));
        tab.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 10'h0B9, 0, 1));
        tab.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 10'h0B9, 0, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 1, 0, 10'h0FA, 1, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 1, 10'h17C, 0, 0));
        tab.push_back(mk(0, 1, 8'h00, 0, 0, 1, 1, 10'h18B, 0, 0));
        tab.push_back(mk(0, 1, 8'hFC, 1, 0, 0, 0, 10'h23C, 0, 0));
        tab.push_back(mk(0, 1, 8'h07, 0, 0, 0, 0, 10'h347, 1, 0));
        tab.push_back(mk(0, 1, 8'h07, 0, 0, 0, 0, 10'h0B8, 0, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 0, 10'h17C, 1, 0));
        tab.push_back(mk(1, 1, 8'hBC, 1, 0, 0, 0, 10'h000, 0, 0));
        tab.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 0, 10'h17C, 1, 0));
        tab.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 10'h000, 0, 0));

        apply(mk(1, 0, 8'h00, 0, 0, 0, 0, 10'h000, 0, 0), 1'b0);
        apply(mk(1, 1, 8'hBC, 1, 0, 0, 0, 10'h000, 0, 0), 1'b0);
        foreach (tab[i]) apply(tab[i], 1'b1);

        // every D code and legal K code, cycling the reverse/invert settings, with idle gaps
        for (int i = 0; i < 268; i++) begin
            if (i < 256) begin b = i[7:0]; k = 1'b0; end
            else begin b = KC[i-256]; k = 1'b1; end
            ri = i[1:0];
            repeat ($urandom_range(0, 2))
                apply(mk(0, 0, 8'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom), 0, 0, 0), 1'b0);
            apply(mk(0, 1, b, k, 0, ri[1], ri[0], 0, 0, 0), 1'b0);
        end

        // random bytes, including illegal K requests and forced RD-
        for (int i = 0; i < 60; i++) begin
            apply(mk(0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                     1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 0, 0, 0), 1'b0);
        end

        apply(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        @(negedge clk_i);
        #1;
        chk("sb_drain", sbq.size(), 0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
